branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_sat_ctr.sv | 22 ++
 rtl/branch_predictor.sv | 119 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch predictor types and constants.
// Default sizes, weak counter values, entry layout.
package bp_pkg;

  localparam int BP_ENTRIES = 64;
  localparam int BP_PC_W    = 32;
  localparam int BP_CTR_W   = 2;
  localparam int BP_HIST_W  = 6;

  localparam int BP_IDX_W = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

  // Weak states for the default counter width.
  localparam logic [BP_CTR_W-1:0] BP_CTR_WT  = 2'b10;
  localparam logic [BP_CTR_W-1:0] BP_CTR_WNT = 2'b01;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

  // Weak-taken value for any counter width.
  function automatic int ctr_weak_taken(int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter step (combinational).
// Ports: ctr current value, inc direction, nxt result.
module bp_sat_ctr #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = ctr;
    if (inc) begin
      if (ctr != '1)
        nxt = ctr + W'(1);
    end else begin
      if (ctr != '0)
        nxt = ctr - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BTB with 2-bit style counters and global history.
// Lookup: lk_pc -> pred_hit/pred_taken/pred_target (same cycle).
// Update: upd_valid/upd_pc/upd_taken/upd_target (next edge).
// ghr: global history. Sync active-high reset.
// Optional macro BP_GSHARE_EN: index = PC index ^ ghr.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int PC_W    = BP_PC_W,
  parameter int CTR_W   = BP_CTR_W,
  parameter int HIST_W  = BP_HIST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic [HIST_W-1:0] ghr
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_WT =
    CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT =
    CTR_W'(ctr_weak_taken(CTR_W) - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] upd_tag;
  entry_t           lk_e;
  entry_t           upd_e;
  entry_t           upd_new;
  logic             upd_hit;
  logic [CTR_W-1:0] ctr_nxt;
  logic             unused_bits;

  assign unused_bits = ^upd_pc[1:0];

  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] hist_x;

  always_comb begin
    hist_x = '0;
    hist_x[HIST_W-1:0] = ghr;
  end

  assign lk_idx  = lk_pc[IDX_W+1:2] ^ hist_x;
  assign upd_idx = upd_pc[IDX_W+1:2] ^ hist_x;
`else
  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];
`endif

  // Lookup reads the table as it stands; no bypass of the
  // update being written this cycle.
  assign lk_e       = tbl[lk_idx];
  assign pred_hit   = lk_e.valid && (lk_e.tag == lk_tag);
  assign pred_taken = pred_hit && lk_e.ctr[CTR_W-1];
  assign pred_target = pred_taken ? lk_e.target
                                  : lk_pc + PC_W'(4);

  assign upd_e   = tbl[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

  bp_sat_ctr #(
    .W (CTR_W)
  ) u_ctr (
    .ctr (upd_e.ctr),
    .inc (upd_taken),
    .nxt (ctr_nxt)
  );

  always_comb begin
    upd_new       = upd_e;
    upd_new.valid = 1'b1;
    upd_new.tag   = upd_tag;
    if (upd_hit) begin
      upd_new.ctr = ctr_nxt;
      if (upd_taken)
        upd_new.target = upd_target;
    end else begin
      upd_new.target = upd_target;
      upd_new.ctr    = upd_taken ? CTR_WT : CTR_WNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '0;
      ghr <= '0;
    end else if (upd_valid) begin
      tbl[upd_idx] <= upd_new;
      ghr <= HIST_W'({ghr, upd_taken});
    end
  end

endmodule
